// File: rtl/memgame_pkg.sv
// Shared types and constants for the card-matching game control path.
package memgame_pkg;

  // Control FSM states.
  typedef enum logic [2:0] {
    PICK1 = 3'd0,
    PICK2 = 3'd1,
    RD1   = 3'd2,
    RD2   = 3'd3,
    CMP   = 3'd4,
    HOLD  = 3'd5,
    OVER  = 3'd6
  } mg_state_t;

  // Bit positions inside the keys[3:0] pulse vector.
  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;

  // Width of the saturating move counter.
  localparam int unsigned MOVES_W = 16;

endpackage

// File: rtl/cursor_nav.sv
// Grid cursor: row/col registers driven by arrow-key pulses, with
// fixed key priority and a per-instance wrap-or-clamp edge rule.
module cursor_nav
  import memgame_pkg::*;
#(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 6,
  parameter int unsigned WRAP = 0,
  localparam int unsigned IDX_W = $clog2(ROWS * COLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [3:0]       keys,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;

  // Next position: clear wins, then one move per cycle, up > down > left > right.
  always_comb begin
    row_n = row;
    col_n = col;
    if (clr) begin
      row_n = '0;
      col_n = '0;
    end else if (en) begin
      if (keys[KEY_UP]) begin
        if (row != '0)       row_n = row - ROW_W'(1);
        else if (WRAP != 0)  row_n = ROW_MAX;
      end else if (keys[KEY_DOWN]) begin
        if (row != ROW_MAX)  row_n = row + ROW_W'(1);
        else if (WRAP != 0)  row_n = '0;
      end else if (keys[KEY_LEFT]) begin
        if (col != '0)       col_n = col - COL_W'(1);
        else if (WRAP != 0)  col_n = COL_MAX;
      end else if (keys[KEY_RIGHT]) begin
        if (col != COL_MAX)  col_n = col + COL_W'(1);
        else if (WRAP != 0)  col_n = '0;
      end
    end
  end

  // Position registers; the linear index is registered alongside them.
  always_ff @(posedge clock) begin
    if (reset) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else begin
      row <= row_n;
      col <= col_n;
      idx <= IDX_W'(row_n) * IDX_W'(COLS) + IDX_W'(col_n);
    end
  end

endmodule

// File: rtl/memory_game_ctrl.sv
// Card-matching game control: cursor, two-card selection, board RAM
// fetch, match/mismatch scoring, reveal window, move count, game over.
module memory_game_ctrl
  import memgame_pkg::*;
#(
  parameter int unsigned ROWS        = 6,
  parameter int unsigned COLS        = 6,
  parameter int unsigned SYM_W       = 5,
  parameter int unsigned WRAP        = 0,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  localparam int unsigned N          = ROWS * COLS,
  localparam int unsigned IDX_W      = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         keys,
  input  logic               A,
  output logic [IDX_W-1:0]   sym_addr,
  input  logic [SYM_W-1:0]   sym_data,
  output logic [IDX_W-1:0]   cursor,
  output logic [IDX_W-1:0]   card1Loc,
  output logic [IDX_W-1:0]   card2Loc,
  output logic [N-1:0]       LEDs,
  output logic [N-1:0]       found,
  output logic               match,
  output logic               mismatch,
  output logic [MOVES_W-1:0] moves,
  output logic               GO
);

  localparam int unsigned HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [MOVES_W-1:0] MOVES_MAX = '1;

  // Elaboration-time parameter sanity.
  if (N % 2 != 0) begin : g_odd_grid
    $error("memory_game_ctrl: ROWS*COLS must be even");
  end
  if (ROWS < 2 || COLS < 2) begin : g_small_grid
    $error("memory_game_ctrl: ROWS and COLS must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("memory_game_ctrl: HOLD_CYCLES must be at least 1");
  end

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
    return N'(1) << i;
  endfunction

  mg_state_t          state, state_n;
  logic [IDX_W-1:0]   card1_n, card2_n;
  logic [N-1:0]       found_n, leds_n;
  logic [MOVES_W-1:0] moves_n;
  logic               match_n, mismatch_n, go_n;
  logic [HC_W-1:0]    hold_cnt, hold_n;
  logic [SYM_W-1:0]   sym1, sym1_n;
  logic               nav_en, nav_clr;
  logic               cursor_found;

  cursor_nav #(
    .ROWS (ROWS),
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_nav (
    .clock (clock),
    .reset (reset),
    .en    (nav_en),
    .clr   (nav_clr),
    .keys  (keys),
    .idx   (cursor)
  );

  assign cursor_found = |(found & onehot(cursor));

  // Board RAM address: the two selected cards during the fetch, else the cursor.
  always_comb begin
    sym_addr = cursor;
    case (state)
      RD1:     sym_addr = card1Loc;
      RD2:     sym_addr = card2Loc;
      default: sym_addr = cursor;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    card1_n    = card1Loc;
    card2_n    = card2Loc;
    found_n    = found;
    moves_n    = moves;
    match_n    = 1'b0;
    mismatch_n = 1'b0;
    hold_n     = hold_cnt;
    sym1_n     = sym1;
    nav_en     = 1'b0;
    nav_clr    = 1'b0;
    leds_n     = '0;
    go_n       = 1'b0;

    case (state)
      PICK1: begin
        nav_en = 1'b1;
        if (A && !cursor_found) begin
          card1_n = cursor;
          state_n = PICK2;
        end
      end
      PICK2: begin
        nav_en = 1'b1;
        if (A && !cursor_found && (cursor != card1Loc)) begin
          card2_n = cursor;
          state_n = RD1;
        end
      end
      RD1: state_n = RD2;
      RD2: begin
        sym1_n  = sym_data;
        state_n = CMP;
      end
      CMP: begin
        if (moves != MOVES_MAX) moves_n = moves + MOVES_W'(1);
        if (sym_data == sym1) begin
          found_n = found | onehot(card1Loc) | onehot(card2Loc);
          match_n = 1'b1;
          state_n = (&found_n) ? OVER : PICK1;
        end else begin
          mismatch_n = 1'b1;
          hold_n     = HOLD_LOAD;
          state_n    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_n = PICK1;
        else                hold_n  = hold_cnt - HC_W'(1);
      end
      OVER: begin
        if (A) begin
          found_n = '0;
          moves_n = '0;
          nav_clr = 1'b1;
          state_n = PICK1;
        end
      end
      default: state_n = PICK1;
    endcase

    // Found cards plus whichever selections are currently on display.
    leds_n = found_n;
    if (state_n == PICK2 || state_n == RD1 || state_n == RD2 ||
        state_n == CMP || state_n == HOLD) begin
      leds_n = leds_n | onehot(card1_n);
    end
    if (state_n == RD1 || state_n == RD2 || state_n == CMP || state_n == HOLD) begin
      leds_n = leds_n | onehot(card2_n);
    end
    go_n = (state_n == OVER);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PICK1;
      card1Loc <= '0;
      card2Loc <= '0;
      found    <= '0;
      moves    <= '0;
      match    <= 1'b0;
      mismatch <= 1'b0;
      GO       <= 1'b0;
      LEDs     <= '0;
      hold_cnt <= '0;
      sym1     <= '0;
    end else begin
      state    <= state_n;
      card1Loc <= card1_n;
      card2Loc <= card2_n;
      found    <= found_n;
      moves    <= moves_n;
      match    <= match_n;
      mismatch <= mismatch_n;
      GO       <= go_n;
      LEDs     <= leds_n;
      hold_cnt <= hold_n;
      sym1     <= sym1_n;
    end
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: 6x6 clamping instance driven by directed and
// random stimulus against a grid-level model with a result scoreboard, plus
// a 2x2 wrapping instance played to game over.
module tb_memory_game_ctrl;

  localparam int R1 = 6;
  localparam int C1 = 6;
  localparam int N1 = 36;
  localparam int H1 = 4;
  localparam bit W1 = 1'b0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance 1: 6x6, clamp, short hold ----------------
  logic        reset, a;
  logic [3:0]  keys;
  logic [5:0]  sym_addr, cursor, card1, card2;
  logic [4:0]  sym_data;
  logic [N1-1:0] leds, found;
  logic        match, mismatch, go;
  logic [15:0] moves;
  logic [4:0]  board [0:N1-1];

  memory_game_ctrl #(.ROWS(R1), .COLS(C1), .SYM_W(5), .WRAP(0), .HOLD_CYCLES(H1)) u_dut (
    .clock(clock), .reset(reset), .keys(keys), .A(a), .sym_addr(sym_addr),
    .sym_data(sym_data), .cursor(cursor), .card1Loc(card1), .card2Loc(card2),
    .LEDs(leds), .found(found), .match(match), .mismatch(mismatch),
    .moves(moves), .GO(go));

  always @(posedge clock) sym_data <= board[sym_addr];

  // ---------------- instance 2: 2x2, wrap ----------------
  logic        rst2, a2;
  logic [3:0]  keys2;
  logic [1:0]  sym_addr2, cursor2, card1_2, card2_2;
  logic [4:0]  sym_data2;
  logic [3:0]  leds2, found2;
  logic        match2, mismatch2, go2;
  logic [15:0] moves2;
  logic [4:0]  board2 [0:3];

  memory_game_ctrl #(.ROWS(2), .COLS(2), .SYM_W(5), .WRAP(1), .HOLD_CYCLES(3)) u_dut2 (
    .clock(clock), .reset(rst2), .keys(keys2), .A(a2), .sym_addr(sym_addr2),
    .sym_data(sym_data2), .cursor(cursor2), .card1Loc(card1_2), .card2Loc(card2_2),
    .LEDs(leds2), .found(found2), .match(match2), .mismatch(mismatch2),
    .moves(moves2), .GO(go2));

  always @(posedge clock) sym_data2 <= board2[sym_addr2];

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit            is_match;
    int            cyc;
    logic [15:0]   moves;
    logic [N1-1:0] found;
    bit            go;
  } exp_t;

  exp_t sb[$];

  // Monitor: every result pulse must correspond to a predicted pair attempt.
  always @(negedge clock) begin
    exp_t e;
    if (match === 1'b1 || mismatch === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got match=%b mismatch=%b, expected none", match, mismatch);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind",  {62'd0, match, mismatch}, {62'd0, e.is_match, !e.is_match});
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("moves",       64'(moves), 64'(e.moves));
        chk("found",       64'(found), 64'(e.found));
        chk("go",          64'(go), 64'(e.go));
      end
    end
  end

  // ---------------- grid-level model for instance 1 ----------------
  int m_row = 0, m_col = 0, m_phase = 0, m_c1 = 0, m_c2 = 0, m_moves = 0;
  logic [N1-1:0] m_found = '0;

  function automatic logic [N1-1:0] oh(input int i);
    logic [N1-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic apply_key(input logic [3:0] m);
    if (m[0]) begin
      if (m_row > 0) m_row--; else if (W1) m_row = R1 - 1;
    end else if (m[1]) begin
      if (m_row < R1 - 1) m_row++; else if (W1) m_row = 0;
    end else if (m[2]) begin
      if (m_col > 0) m_col--; else if (W1) m_col = C1 - 1;
    end else if (m[3]) begin
      if (m_col < C1 - 1) m_col++; else if (W1) m_col = 0;
    end
  endtask

  task automatic do_key(input logic [3:0] m);
    @(negedge clock);
    keys = m;
    apply_key(m);
    @(negedge clock);
    keys = 4'b0;
    chk("cursor", 64'(cursor), 64'(m_row * C1 + m_col));
  endtask

  task automatic goto_card(input int idx);
    int tr, tc;
    tr = idx / C1;
    tc = idx % C1;
    for (int g = 0; g < 12 && m_row != tr; g++) do_key(m_row > tr ? 4'b0001 : 4'b0010);
    for (int g = 0; g < 12 && m_col != tc; g++) do_key(m_col > tc ? 4'b0100 : 4'b1000);
  endtask

  task automatic press_a();
    int c, t0;
    bit pair, mis;
    exp_t e;
    logic [N1-1:0] shown;
    c = m_row * C1 + m_col;
    pair = 1'b0;
    mis = 1'b0;
    shown = '0;
    @(negedge clock);
    a = 1'b1;
    t0 = cyc;
    if (m_phase == 0) begin
      if (!m_found[c]) begin
        m_c1 = c;
        m_phase = 1;
      end
    end else if (!m_found[c] && c != m_c1) begin
      pair = 1'b1;
      m_phase = 0;
      m_c2 = c;
      shown = m_found | oh(m_c1) | oh(c);
      e.is_match = (board[m_c1] == board[c]);
      mis = !e.is_match;
      if (m_moves < 65535) m_moves++;
      if (e.is_match) m_found = m_found | oh(m_c1) | oh(c);
      e.cyc = t0 + 4;
      e.moves = 16'(m_moves);
      e.found = m_found;
      e.go = &m_found;
      sb.push_back(e);
    end
    @(negedge clock);
    a = 1'b0;
    if (!pair) begin
      chk("card1Loc", 64'(card1), 64'(m_c1));
      chk("leds_pick", 64'(leds), 64'(m_found | (m_phase == 1 ? oh(m_c1) : '0)));
    end else begin
      for (int k = 2; k <= 4 + H1; k++) begin
        @(negedge clock);
        if (k <= 3) chk("leds_fetch", 64'(leds), 64'(shown));
        else if (k <= 3 + H1) chk("leds_result", 64'(leds), 64'(mis ? shown : m_found));
        if (mis && k == 5) begin
          keys = 4'b1000;
          a = 1'b1;
        end
        if (k == 6) begin
          keys = 4'b0;
          a = 1'b0;
        end
      end
      chk("leds_after", 64'(leds), 64'(m_found));
      chk("cursor_after", 64'(cursor), 64'(m_row * C1 + m_col));
      chk("card1_after", 64'(card1), 64'(m_c1));
      chk("card2_after", 64'(card2), 64'(m_c2));
    end
  endtask

  // ---------------- instance 2 helpers ----------------
  task automatic key2(input logic [3:0] m);
    @(negedge clock);
    keys2 = m;
    @(negedge clock);
    keys2 = 4'b0;
  endtask

  task automatic a2_pulse();
    @(negedge clock);
    a2 = 1'b1;
    @(negedge clock);
    a2 = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end within its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; keys = 4'b0; a = 1'b0;
    rst2 = 1'b1; keys2 = 4'b0; a2 = 1'b0;
    for (int i = 0; i < N1; i++) board[i] = 5'($urandom_range(0, 7));
    board[0] = 5'd9;
    board[7] = 5'd9;
    board[1] = 5'd3;
    board2[0] = 5'd5; board2[1] = 5'd7; board2[2] = 5'd5; board2[3] = 5'd7;

    repeat (3) @(negedge clock);
    chk("rst_cursor", 64'(cursor), 64'd0);
    chk("rst_card1",  64'(card1), 64'd0);
    chk("rst_card2",  64'(card2), 64'd0);
    chk("rst_found",  64'(found), 64'd0);
    chk("rst_leds",   64'(leds), 64'd0);
    chk("rst_moves",  64'(moves), 64'd0);
    chk("rst_pulses", {61'd0, match, mismatch, go}, 64'd0);
    reset = 1'b0;

    // Clamp at top edge, then walk right.
    repeat (8) do_key(4'b0001);
    repeat (3) do_key(4'b1000);
    // Multi-bit priority: down beats left/right, left beats right.
    do_key(4'b1110);
    do_key(4'b1100);

    // Mismatch 0/1, then match 0/7.
    goto_card(0); press_a();
    goto_card(1); press_a();
    goto_card(0); press_a();
    goto_card(7); press_a();

    // Same card twice, then a found card: both ignored in PICK2.
    goto_card(2); press_a(); press_a();
    goto_card(0); press_a();
    goto_card(3); press_a();

    // Reset while the pair fetch is in RD2: no result, all outputs cleared.
    goto_card(10); press_a();
    goto_card(11);
    @(negedge clock); a = 1'b1;
    @(negedge clock); a = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("rd2rst_cursor", 64'(cursor), 64'd0);
    chk("rd2rst_cards",  64'({card1, card2}), 64'd0);
    chk("rd2rst_found",  64'(found), 64'd0);
    chk("rd2rst_leds",   64'(leds), 64'd0);
    chk("rd2rst_moves",  64'(moves), 64'd0);
    chk("rd2rst_pulses", {61'd0, match, mismatch, go}, 64'd0);
    reset = 1'b0;
    m_row = 0; m_col = 0; m_phase = 0; m_c1 = 0; m_c2 = 0; m_moves = 0; m_found = '0;
    @(negedge clock);
    chk("rd2rst_nopulse", {62'd0, match, mismatch}, 64'd0);

    // Random play.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) press_a();
      else do_key(4'($urandom_range(1, 15)));
    end

    // 2x2 wrapping instance played to game over and restarted.
    @(negedge clock);
    rst2 = 1'b0;
    key2(4'b0100);
    chk("wrap_left", 64'(cursor2), 64'd1);
    key2(4'b0001);
    chk("wrap_up", 64'(cursor2), 64'd3);
    a2_pulse();
    key2(4'b0010);
    chk("wrap_down", 64'(cursor2), 64'd1);
    a2_pulse();
    repeat (3) @(negedge clock);
    chk("g2_match1", 64'(match2), 64'd1);
    chk("g2_found1", 64'(found2), 64'hA);
    chk("g2_moves1", 64'(moves2), 64'd1);
    chk("g2_go1",    64'(go2), 64'd0);
    @(negedge clock);
    chk("g2_pulse_width", 64'(match2), 64'd0);
    key2(4'b0100);
    chk("g2_cursor0", 64'(cursor2), 64'd0);
    a2_pulse();
    key2(4'b0001);
    chk("g2_cursor2", 64'(cursor2), 64'd2);
    a2_pulse();
    repeat (3) @(negedge clock);
    chk("g2_match2", 64'(match2), 64'd1);
    chk("g2_found2", 64'(found2), 64'hF);
    chk("g2_moves2", 64'(moves2), 64'd2);
    chk("g2_go2",    64'(go2), 64'd1);
    key2(4'b1000);
    chk("g2_over_nokey", 64'(cursor2), 64'd2);
    chk("g2_over_hold",  64'(go2), 64'd1);
    a2_pulse();
    chk("g2_restart_go",     64'(go2), 64'd0);
    chk("g2_restart_found",  64'(found2), 64'd0);
    chk("g2_restart_moves",  64'(moves2), 64'd0);
    chk("g2_restart_cursor", 64'(cursor2), 64'd0);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
